axis2native_ppc: RTL
====================

AXIS2NATIVE_PPC -- requirements
Module: axis2native_ppc

Interface
REQ-001 SHALL have parameter DWID, default 24, bits per pixel.
REQ-002 SHALL have parameter PPC, default 1, pixels per beat, legal values 1/2/4.
REQ-003 SHALL have parameter BUF_AWID, default 10, buffer depth 2^BUF_AWID beats.
REQ-004 SHALL have parameter PREFILL, default 16, buffer level (beats) required before alignment; legal range 1..2^BUF_AWID.
REQ-005 SHALL have parameter BLANK_VAL, default 0, DWID-bit pixel value driven on underflow.
REQ-006 SHALL use one clock and an asynchronous active-low reset, per the port list below.
REQ-007 SHALL have port natv_clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports s_tdata in PPC*DWID, s_tvalid in 1, s_tready out 1, s_tlast in 1, s_tuser in 1; AXI-stream video input.
REQ-010 SHALL have inputs vtg_hsync, vtg_vsync, vtg_hblank, vtg_vblank, vtg_active, vtg_fid, each 1 bit, free-running timing generator.
REQ-011 SHALL have output vtg_ce, 1, held 1 outside reset.
REQ-012 SHALL have outputs natv_data PPC*DWID, natv_hsync, natv_vsync, natv_hblank, natv_vblank, natv_active, natv_fid, each 1 bit.
REQ-013 SHALL have outputs locked 1, err_underflow 1, err_sof 1, err_eol 1, and input err_clr 1.

Function
REQ-014 Buffer: synchronous FIFO, 2^BUF_AWID entries of PPC*DWID+2 bits {tuser,tlast,tdata}; level counter BUF_AWID+1 bits.
REQ-015 s_tready SHALL be 1 iff level < 2^BUF_AWID; push = s_tvalid && s_tready; a same-cycle pop does not open room in that cycle.
REQ-016 Frame start: register seen_vb set when vtg_vblank=1, cleared when vtg_active=1; vtg_sof = vtg_active && seen_vb.
REQ-017 FSM states SEEK, ALIGN, RUN; reset state SEEK.
REQ-018 SEEK: pop and discard head while non-empty and head tuser=0; if head tuser=1 and level >= PREFILL -> ALIGN without pop.
REQ-019 ALIGN: no pop; on vtg_sof -> RUN and pop head in that same cycle.
REQ-020 RUN: pop on every cycle with vtg_active=1 and FIFO non-empty.
REQ-021 Underflow: RUN with vtg_active=1 and FIFO empty -> data BLANK_VAL replicated PPC times, set err_underflow, -> SEEK.
REQ-022 Early SOF: RUN, vtg_active=1, not vtg_sof, head tuser=1 -> no pop, blank data, set err_sof, -> SEEK (head kept).
REQ-023 Late SOF: RUN, vtg_sof, head tuser=0 -> no pop, blank data, set err_sof, -> SEEK.
REQ-024 EOL check: popped beat with tlast=1 while next cycle vtg_active=1, or last active beat of a line (vtg_active falling) popped with tlast=0 -> set err_eol; no state change.
REQ-025 Outputs registered, latency exactly 1 cycle: natv_* sync/blank/fid = vtg_* delayed one clock; natv_active = vtg_active delayed one clock in RUN, 0 otherwise; natv_data = popped tdata or BLANK_VAL.
REQ-026 locked = 1 iff state is RUN.
REQ-027 Error flags sticky; err_clr=1 clears all three next cycle; a same-cycle set wins over clear.
REQ-028 Simultaneous push and pop at any level SHALL keep level unchanged and data ordered.

Reset
REQ-029 rst_n=0 asynchronously: FIFO empty, state SEEK, seen_vb 0, s_tready 0, vtg_ce 0, all natv_* 0, locked 0, error flags 0.
REQ-030 After rst_n deasserts, s_tready and vtg_ce go 1 on first clock edge; reset mid-frame discards all buffered data.

Verification
REQ-031 PPC=2, 1920x1080 frame, stream prefilled: locked rises at first vtg_sof, natv_data matches input beats in order, no error flags.
REQ-032 Stream starting mid-frame (no tuser): words discarded until tuser beat, lock at following vtg_sof, err_sof=0.
REQ-033 Source stalls 10 cycles mid-line: err_underflow=1, natv_data=BLANK_VAL, locked=0, relock at next frame.
REQ-034 Line shortened by 1 beat: err_eol=1, lock retained; err_clr pulse -> err_eol=0.
REQ-035 Fill FIFO to 2^BUF_AWID with VTG in vblank: s_tready=0, no beat lost or duplicated once drained.
REQ-036 Assert rst_n=0 mid-line: all outputs 0 immediately, level 0; recovery to lock within one frame.

Source files
------------

// File: rtl/axis2native_ppc.sv
// axis2native_ppc: replays a buffered AXI-stream video feed in lockstep with a
// free-running native timing generator, dropping lock on any framing error.
module axis2native_ppc #(
  parameter int              DWID      = 24,
  parameter int              PPC       = 1,
  parameter int              BUF_AWID  = 10,
  parameter int              PREFILL   = 16,
  parameter logic [DWID-1:0] BLANK_VAL = '0
) (
  input  logic                natv_clk,
  input  logic                rst_n,
  input  logic [PPC*DWID-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                s_tuser,
  input  logic                vtg_hsync,
  input  logic                vtg_vsync,
  input  logic                vtg_hblank,
  input  logic                vtg_vblank,
  input  logic                vtg_active,
  input  logic                vtg_fid,
  output logic                vtg_ce,
  output logic [PPC*DWID-1:0] natv_data,
  output logic                natv_hsync,
  output logic                natv_vsync,
  output logic                natv_hblank,
  output logic                natv_vblank,
  output logic                natv_active,
  output logic                natv_fid,
  output logic                locked,
  output logic                err_underflow,
  output logic                err_sof,
  output logic                err_eol,
  input  logic                err_clr
);
  localparam int DW    = PPC*DWID;
  localparam int DEPTH = 2**BUF_AWID;
  localparam logic [BUF_AWID:0] FULL_L    = (BUF_AWID+1)'(DEPTH);
  localparam logic [BUF_AWID:0] PREFILL_L = (BUF_AWID+1)'(PREFILL);

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {SEEK, ALIGN, RUN} state_t;

  beat_t               mem_q [DEPTH];
  logic [BUF_AWID-1:0] wptr_q, rptr_q;
  logic [BUF_AWID:0]   level_q;
  logic                en_q;
  logic                seen_vb_q;
  state_t              state_q, state_d;

  beat_t head;
  logic  empty, push, pop, vtg_sof, out_pop;
  logic  ufl_set, sof_set, eol_set;

  logic [DW-1:0] data_q, data_d;
  logic          active_q, active_d;
  logic          hsync_q, vsync_q, hblank_q, vblank_q, fid_q;
  logic          pop_q, tlast_q;
  logic          eufl_q, esof_q, eeol_q;

  assign head     = mem_q[rptr_q];
  assign empty    = (level_q == '0);
  // Room is judged on the registered level only, so a pop never frees a slot in its own cycle.
  assign s_tready = en_q && (level_q < FULL_L);
  assign push     = s_tvalid && s_tready;
  assign vtg_sof  = vtg_active && seen_vb_q;
  assign vtg_ce   = en_q;

  always_ff @(posedge natv_clk)
    if (push) mem_q[wptr_q] <= {s_tuser, s_tlast, s_tdata};

  always_ff @(posedge natv_clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      en_q      <= 1'b0;
      seen_vb_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (vtg_vblank)      seen_vb_q <= 1'b1;
      else if (vtg_active) seen_vb_q <= 1'b0;
    end

  // FSM: state register
  always_ff @(posedge natv_clk or negedge rst_n)
    if (!rst_n) state_q <= SEEK;
    else        state_q <= state_d;

  // FSM: next state and buffer pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ufl_set = 1'b0;
    sof_set = 1'b0;
    unique case (state_q)
      SEEK:
        if (!empty) begin
          if (!head.user)                pop     = 1'b1;
          else if (level_q >= PREFILL_L) state_d = ALIGN;
        end
      ALIGN:
        if (vtg_sof && !empty) begin
          state_d = RUN;
          pop     = 1'b1;
        end
      RUN:
        if (vtg_active) begin
          if (empty) begin
            ufl_set = 1'b1;
            state_d = SEEK;
          end else if (head.user != vtg_sof) begin
            // Frame boundary disagreement either way; the head beat stays for the next seek.
            sof_set = 1'b1;
            state_d = SEEK;
          end else begin
            pop = 1'b1;
          end
        end
      default: state_d = SEEK;
    endcase
  end

  // FSM: output values for the next cycle
  always_comb begin
    out_pop  = pop && (state_q != SEEK);
    data_d   = {PPC{BLANK_VAL}};
    if (out_pop) data_d = head.data;
    active_d = vtg_active && (state_d == RUN);
    // tlast must coincide with the last active cycle of the line.
    eol_set  = pop_q && (tlast_q == vtg_active);
  end

  always_ff @(posedge natv_clk or negedge rst_n)
    if (!rst_n) begin
      data_q   <= '0;
      active_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      fid_q    <= 1'b0;
      pop_q    <= 1'b0;
      tlast_q  <= 1'b0;
      eufl_q   <= 1'b0;
      esof_q   <= 1'b0;
      eeol_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      active_q <= active_d;
      hsync_q  <= vtg_hsync;
      vsync_q  <= vtg_vsync;
      hblank_q <= vtg_hblank;
      vblank_q <= vtg_vblank;
      fid_q    <= vtg_fid;
      pop_q    <= out_pop;
      tlast_q  <= head.last;
      eufl_q   <= ufl_set || (eufl_q && !err_clr);
      esof_q   <= sof_set || (esof_q && !err_clr);
      eeol_q   <= eol_set || (eeol_q && !err_clr);
    end

  assign natv_data     = data_q;
  assign natv_active   = active_q;
  assign natv_hsync    = hsync_q;
  assign natv_vsync    = vsync_q;
  assign natv_hblank   = hblank_q;
  assign natv_vblank   = vblank_q;
  assign natv_fid      = fid_q;
  assign locked        = (state_q == RUN);
  assign err_underflow = eufl_q;
  assign err_sof       = esof_q;
  assign err_eol       = eeol_q;

endmodule
